// File: rtl/vga_obj_renderer.sv
// VGA timing generator compositing N_OBJ rectangles over a split two-colour background.
// Latency: colour and syncs trail the h/v counters by exactly 2 pixel enables.
// Backpressure: obj_wr_ready drops only in the single commit clk; a held write lands next clk.
module vga_obj_renderer #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 4,
    parameter int N_OBJ    = 9,
    parameter int COORD_W  = 11,
    localparam int IDX_W   = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      obj_wr_en,
    output logic                      obj_wr_ready,
    input  logic [IDX_W-1:0]          obj_wr_idx,
    input  logic signed [COORD_W-1:0] obj_wr_x,
    input  logic signed [COORD_W-1:0] obj_wr_y,
    input  logic [5:0]                obj_wr_hw,
    input  logic [6:0]                obj_wr_hh,
    input  logic [11:0]               obj_wr_color,
    input  logic                      obj_wr_vis,
    input  logic [COORD_W-1:0]        bg_split,
    input  logic [11:0]               bg_left_color,
    input  logic [11:0]               bg_right_color,
    output logic                      frame_start,
    output logic [3:0]                vgaRed,
    output logic [3:0]                vgaGreen,
    output logic [3:0]                vgaBlue,
    output logic                      hsync,
    output logic                      vsync
);

    localparam int HT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW    = COORD_W;
    localparam int EW    = COORD_W + 1;

    typedef struct packed {
        logic signed [CW-1:0] x;
        logic signed [CW-1:0] y;
        logic [5:0]           hw;
        logic [6:0]           hh;
        logic [11:0]          color;
        logic                 vis;
    } obj_t;

    logic [DIV_W-1:0] div_cnt;
    logic             pe;
    logic [CW-1:0]    h_cnt;
    logic [CW-1:0]    v_cnt;
    logic             commit;
    logic             wr_acc;
    obj_t             wr_obj;
    obj_t             shadow [N_OBJ];
    obj_t             active [N_OBJ];

    logic [N_OBJ-1:0] hit_d;
    logic [N_OBJ-1:0] hit_q;
    logic             bg_left_q;
    logic             act_q;
    logic             hs_raw_q;
    logic             vs_raw_q;
    logic [11:0]      pix_col;
    logic [11:0]      rgb_q;

    // ---------------- S0: pixel enable and counters ----------------
    assign pe = (div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (pe) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pe) begin
            if (h_cnt == CW'(HT - 1)) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == CW'(VT - 1)) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // The commit clk is the pe that moves the counters onto (0, V_ACTIVE).
    assign commit       = pe && (h_cnt == CW'(HT - 1)) && (v_cnt == CW'(V_ACTIVE - 1));
    assign frame_start  = commit;
    assign obj_wr_ready = ~commit;
    assign wr_acc       = obj_wr_en && obj_wr_ready && (int'(obj_wr_idx) < N_OBJ);

    always_comb begin
        wr_obj       = '0;
        wr_obj.x     = obj_wr_x;
        wr_obj.y     = obj_wr_y;
        wr_obj.hw    = obj_wr_hw;
        wr_obj.hh    = obj_wr_hh;
        wr_obj.color = obj_wr_color;
        wr_obj.vis   = obj_wr_vis;
    end

    // ---------------- shadow / active object registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_OBJ; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            if (commit) begin
                for (int i = 0; i < N_OBJ; i++) begin
                    active[i] <= shadow[i];
                end
            end
            if (wr_acc) begin
                shadow[obj_wr_idx] <= wr_obj;
            end
        end
    end

    // ---------------- S1: hit test at COORD_W+1 signed width ----------------
    always_comb begin
        logic signed [EW-1:0] h_s;
        logic signed [EW-1:0] v_s;
        logic signed [EW-1:0] dh;
        logic signed [EW-1:0] dv;
        logic signed [EW-1:0] hwv;
        logic signed [EW-1:0] hhv;
        h_s   = $signed({1'b0, h_cnt});
        v_s   = $signed({1'b0, v_cnt});
        dh    = '0;
        dv    = '0;
        hwv   = '0;
        hhv   = '0;
        hit_d = '0;
        for (int i = 0; i < N_OBJ; i++) begin
            dh  = h_s - $signed({active[i].x[CW-1], active[i].x});
            dv  = v_s - $signed({active[i].y[CW-1], active[i].y});
            hwv = $signed({{(EW-6){1'b0}}, active[i].hw});
            hhv = $signed({{(EW-7){1'b0}}, active[i].hh});
            hit_d[i] = active[i].vis && (dh >= -hwv) && (dh <= hwv)
                                     && (dv >= -hhv) && (dv <= hhv);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q     <= '0;
            bg_left_q <= 1'b0;
            act_q     <= 1'b0;
            hs_raw_q  <= 1'b1;
            vs_raw_q  <= 1'b1;
        end else if (pe) begin
            hit_q     <= hit_d;
            bg_left_q <= (h_cnt < bg_split);
            act_q     <= (h_cnt < CW'(H_ACTIVE)) && (v_cnt < CW'(V_ACTIVE));
            hs_raw_q  <= !((h_cnt >= CW'(H_ACTIVE + H_FP)) &&
                           (h_cnt <  CW'(H_ACTIVE + H_FP + H_SYNC)));
            vs_raw_q  <= !((v_cnt >= CW'(V_ACTIVE + V_FP)) &&
                           (v_cnt <  CW'(V_ACTIVE + V_FP + V_SYNC)));
        end
    end

    // ---------------- S2: priority composite and output registers ----------------
    // Scanning from the top slot down lets the lowest-index hit overwrite the rest.
    always_comb begin
        pix_col = bg_left_q ? bg_left_color : bg_right_color;
        for (int i = N_OBJ - 1; i >= 0; i--) begin
            if (hit_q[i]) begin
                pix_col = active[i].color;
            end
        end
        if (!act_q) begin
            pix_col = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else if (pe) begin
            rgb_q <= pix_col;
            hsync <= hs_raw_q;
            vsync <= vs_raw_q;
        end
    end

    assign vgaRed   = rgb_q[11:8];
    assign vgaGreen = rgb_q[7:4];
    assign vgaBlue  = rgb_q[3:0];

endmodule

// File: tb/tb_vga_obj_renderer.sv
// Bench for vga_obj_renderer on a reduced raster: a time-based scene model plus directed probes.
module tb_vga_obj_renderer;

    localparam int HA = 32, HFP = 2, HSY = 4, HBP = 2;
    localparam int VA = 24, VFP = 2, VSY = 2, VBP = 2;
    localparam int D  = 2, NO = 5, CW = 11, IW = 3;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int F  = HT * VT;
    localparam int WAIT_MAX = 2 * F * D + 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 obj_wr_en = 1'b0;
    logic                 obj_wr_ready;
    logic [IW-1:0]        obj_wr_idx = '0;
    logic signed [CW-1:0] obj_wr_x = '0;
    logic signed [CW-1:0] obj_wr_y = '0;
    logic [5:0]           obj_wr_hw = '0;
    logic [6:0]           obj_wr_hh = '0;
    logic [11:0]          obj_wr_color = '0;
    logic                 obj_wr_vis = 1'b0;
    logic [CW-1:0]        bg_split = '0;
    logic [11:0]          bg_left_color = '0;
    logic [11:0]          bg_right_color = '0;
    logic                 frame_start;
    logic [3:0]           vgaRed, vgaGreen, vgaBlue;
    logic                 hsync, vsync;

    always #5 clk = ~clk;

    vga_obj_renderer #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .CLK_DIV(D), .N_OBJ(NO), .COORD_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .obj_wr_en(obj_wr_en), .obj_wr_ready(obj_wr_ready), .obj_wr_idx(obj_wr_idx),
        .obj_wr_x(obj_wr_x), .obj_wr_y(obj_wr_y), .obj_wr_hw(obj_wr_hw), .obj_wr_hh(obj_wr_hh),
        .obj_wr_color(obj_wr_color), .obj_wr_vis(obj_wr_vis),
        .bg_split(bg_split), .bg_left_color(bg_left_color), .bg_right_color(bg_right_color),
        .frame_start(frame_start),
        .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue),
        .hsync(hsync), .vsync(vsync)
    );

    typedef struct {
        int x; int y; int hw; int hh; int col; bit vis;
    } mobj_t;

    typedef struct {
        int h; int v; logic [11:0] col; string nm;
    } probe_t;

    mobj_t       shd [NO];
    mobj_t       act [NO];
    int          k;
    int          m_p;
    bit          m_pe, m_cm, m_left;
    logic [11:0] exp_col = '0;
    logic        exp_hs = 1'b1, exp_vs = 1'b1;
    bit          mon_fs;
    int          n_chk = 0, n_fail = 0;
    probe_t      tbl [24];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, got, expv, $time);
        end
    endtask

    // Scene rule: first visible slot whose box contains (h,v) wins, else background side.
    function automatic void pix_fn(input int pix, input bit left,
                                   output logic [11:0] c, output logic hs, output logic vs);
        int h, v;
        bit found;
        h = pix % HT;
        v = pix / HT;
        hs = !(h >= HA + HFP && h < HA + HFP + HSY);
        vs = !(v >= VA + VFP && v < VA + VFP + VSY);
        c = '0;
        found = 0;
        if (h < HA && v < VA) begin
            c = left ? bg_left_color : bg_right_color;
            for (int i = 0; i < NO; i++) begin
                if (!found && act[i].vis &&
                    h - act[i].x >= -act[i].hw && h - act[i].x <= act[i].hw &&
                    v - act[i].y >= -act[i].hh && v - act[i].y <= act[i].hh) begin
                    c = 12'(act[i].col);
                    found = 1;
                end
            end
        end
    endfunction

    // Reference model: k = clk edges since reset release, pixel = k / D.
    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            k = 0;
            for (int i = 0; i < NO; i++) begin
                shd[i] = '{0, 0, 0, 0, 0, 1'b0};
                act[i] = '{0, 0, 0, 0, 0, 1'b0};
            end
            exp_col = '0; exp_hs = 1'b1; exp_vs = 1'b1;
        end else begin
            m_pe = (k % D) == D - 1;
            m_p  = k / D;
            if (m_pe) begin
                if (m_p == 0) begin
                    exp_col = '0; exp_hs = 1'b1; exp_vs = 1'b1;
                end else begin
                    pix_fn((m_p - 1) % F, m_left, exp_col, exp_hs, exp_vs);
                end
                m_left = ((m_p % F) % HT) < int'(bg_split);
            end
            m_cm = m_pe && ((m_p % F) == VA * HT - 1);
            if (m_cm) act = shd;
            if (obj_wr_en && !m_cm && int'(obj_wr_idx) < NO)
                shd[obj_wr_idx] = '{int'(obj_wr_x), int'(obj_wr_y), int'(obj_wr_hw),
                                    int'(obj_wr_hh), int'(obj_wr_color), obj_wr_vis};
            k++;
        end
    end

    // Continuous comparison of every output against the model.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            check("pix_reset", {vgaRed, vgaGreen, vgaBlue, hsync, vsync}, {12'h000, 1'b1, 1'b1});
            check("ctrl_reset", {frame_start, obj_wr_ready}, 2'b01);
        end else begin
            mon_fs = ((k % D) == D - 1) && (((k / D) % F) == VA * HT - 1);
            check("pix", {vgaRed, vgaGreen, vgaBlue, hsync, vsync}, {exp_col, exp_hs, exp_vs});
            check("ctrl", {frame_start, obj_wr_ready}, {mon_fs, !mon_fs});
        end
    end

    // Returns at the first clk in which the outputs show pixel (h,v).
    task automatic wait_pix(input int h, input int v, output bit ok);
        ok = 0;
        for (int n = 0; n < WAIT_MAX; n++) begin
            @(negedge clk);
            if (rst_n && (k % D) == 0 && k / D >= 2 && ((k / D - 2) % F) == v * HT + h) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_pix(%0d,%0d): timed out after %0d clk", h, v, WAIT_MAX);
        end
    endtask

    task automatic probe(input string nm, input int h, input int v, input logic [11:0] c);
        bit ok;
        wait_pix(h, v, ok);
        if (ok) check(nm, {vgaRed, vgaGreen, vgaBlue}, c);
    endtask

    task automatic wr(input int idx, input int x, input int y, input int hw, input int hh,
                      input logic [11:0] col, input bit vis);
        bit r;
        r = 0;
        @(negedge clk); #1;
        obj_wr_en = 1'b1; obj_wr_idx = IW'(idx);
        obj_wr_x = CW'(x); obj_wr_y = CW'(y);
        obj_wr_hw = 6'(hw); obj_wr_hh = 7'(hh);
        obj_wr_color = col; obj_wr_vis = vis;
        for (int n = 0; n < 8; n++) begin
            r = obj_wr_ready;
            @(negedge clk);
            if (r) break;
        end
        if (!r) begin
            n_chk++;
            n_fail++;
            $display("FAIL wr_handshake: ready never seen for slot %0d", idx);
        end
        #1;
        obj_wr_en = 1'b0;
    endtask

    initial begin
        bit ok;
        bit got;
        tbl[0]  = '{8, 5, 12'h0F0, "f0_slot0_deferred"};
        tbl[1]  = '{20, 12, 12'h008, "f0_slot1_deferred"};
        tbl[2]  = '{0, 18, 12'h0F0, "f0_slot2_deferred"};
        tbl[3]  = '{15, 0, 12'h0F0, "split_left_edge"};
        tbl[4]  = '{16, 0, 12'h008, "split_right_edge"};
        tbl[5]  = '{6, 3, 12'h00F, "slot0_corner_tl"};
        tbl[6]  = '{5, 5, 12'h0F0, "slot0_left_out"};
        tbl[7]  = '{8, 5, 12'h00F, "slot0_centre"};
        tbl[8]  = '{11, 5, 12'h0F0, "slot0_right_out"};
        tbl[9]  = '{10, 7, 12'h00F, "slot0_corner_br"};
        tbl[10] = '{8, 8, 12'h0F0, "slot0_below_out"};
        tbl[11] = '{17, 10, 12'h008, "slot1_left_out"};
        tbl[12] = '{18, 12, 12'h F00, "slot1_left_edge"};
        tbl[13] = '{20, 12, 12'hF00, "overlap_lo"};
        tbl[14] = '{22, 12, 12'hF00, "overlap_hi"};
        tbl[15] = '{23, 12, 12'h00F, "slot3_only_a"};
        tbl[16] = '{24, 12, 12'h00F, "slot3_only_b"};
        tbl[17] = '{25, 12, 12'h008, "slot3_right_out"};
        tbl[18] = '{0, 15, 12'hFF0, "clip_top_col0"};
        tbl[19] = '{1, 18, 12'hFF0, "clip_col1"};
        tbl[20] = '{2, 18, 12'h0F0, "clip_col2_out"};
        tbl[21] = '{31, 18, 12'h008, "clip_no_wrap"};
        tbl[22] = '{1, 21, 12'hFF0, "clip_bottom"};
        tbl[23] = '{1, 22, 12'h0F0, "clip_below_out"};

        bg_split = CW'(16); bg_left_color = 12'h0F0; bg_right_color = 12'h008;
        repeat (4) @(negedge clk);
        check("rst_hsync", hsync, 1'b1);
        check("rst_vsync", vsync, 1'b1);
        check("rst_color", {vgaRed, vgaGreen, vgaBlue}, 12'h000);
        #1 rst_n = 1'b1;

        // Scene written early in frame 0; must not appear before the commit.
        wait_pix(0, 1, ok);
        wr(0, 8, 5, 2, 2, 12'h00F, 1'b1);
        wr(1, 20, 12, 2, 2, 12'hF00, 1'b1);
        wr(3, 22, 12, 2, 2, 12'h00F, 1'b1);
        wr(2, -3, 18, 4, 3, 12'hFF0, 1'b1);
        wr(5, 16, 12, 40, 40, 12'hFFF, 1'b1);
        wr(4, 16, 12, 40, 40, 12'hFFF, 1'b0);
        for (int i = 0; i < 24; i++) probe(tbl[i].nm, tbl[i].h, tbl[i].v, tbl[i].col);

        // Randomized traffic, including collisions with the commit clk.
        for (int n = 0; n < 3 * F * D; n++) begin
            @(negedge clk); #1;
            obj_wr_en    = ($urandom % 3) == 0;
            obj_wr_idx   = IW'($urandom % 8);
            obj_wr_x     = CW'($urandom_range(0, 56) - 12);
            obj_wr_y     = CW'($urandom_range(0, 46) - 10);
            obj_wr_hw    = 6'($urandom_range(0, 10));
            obj_wr_hh    = 7'($urandom_range(0, 10));
            obj_wr_color = 12'($urandom);
            obj_wr_vis   = ($urandom % 4) != 0;
            if (($urandom % 300) == 0) begin
                bg_split       = CW'($urandom_range(0, 40));
                bg_left_color  = 12'($urandom);
                bg_right_color = 12'($urandom);
            end
        end
        #1 obj_wr_en = 1'b0;
        for (int i = 0; i < NO; i++) wr(i, 0, 0, 0, 0, 12'h000, 1'b0);
        bg_split = CW'(16); bg_left_color = 12'h0F0; bg_right_color = 12'h008;

        // Write raised during the commit clk: refused there, accepted next clk.
        got = 0;
        for (int n = 0; n < WAIT_MAX; n++) begin
            @(negedge clk);
            if (!obj_wr_ready) begin got = 1; break; end
        end
        check("coll_ready_low_seen", got, 1'b1);
        check("coll_frame_start", frame_start, 1'b1);
        #1;
        obj_wr_en = 1'b1; obj_wr_idx = IW'(4);
        obj_wr_x = CW'(28); obj_wr_y = CW'(2);
        obj_wr_hw = 6'd0; obj_wr_hh = 7'd0;
        obj_wr_color = 12'hABC; obj_wr_vis = 1'b1;
        @(negedge clk);
        check("coll_ready_next_clk", obj_wr_ready, 1'b1);
        @(negedge clk); #1;
        obj_wr_en = 1'b0;
        probe("coll_not_this_frame", 28, 2, 12'h008);
        probe("coll_following_frame", 28, 2, 12'hABC);

        // Reset mid-frame clears every slot.
        wait_pix(0, 20, ok);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_hsync", hsync, 1'b1);
        check("mid_rst_vsync", vsync, 1'b1);
        check("mid_rst_color", {vgaRed, vgaGreen, vgaBlue}, 12'h000);
        check("mid_rst_ready", obj_wr_ready, 1'b1);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        probe("post_rst_blank", 28, 2, 12'h008);
        probe("post_rst_bg_left", 0, 18, 12'h0F0);
        probe("post_rst_after_commit", 28, 2, 12'h008);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
